// File: rtl/frame_prefetch_pkg.sv
// frame_prefetch_pkg: shared types and constants for the frame prefetcher.
//   NUM_PIXELS    : pixel count of the default 640x480 frame
//   ADDR_W        : width of pixel / memory addresses
//   pixel_t       : RGB565 pixel
//   state_t       : fetch-control FSM states
//   addr_wrap_inc : address increment wrapping at the frame size
package frame_prefetch_pkg;

  localparam int unsigned NUM_PIXELS = 640 * 480;
  localparam int unsigned ADDR_W     = 19;

  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FLUSH
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_wrap_inc(input logic [ADDR_W-1:0] a,
                                                      input int unsigned       total);
    return (a == ADDR_W'(total - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: synchronous show-ahead FIFO for prefetched pixels.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_flush          : empty the FIFO (overrides push and pop)
//   i_push/i_push_data : write one entry (ignored when full)
//   i_pop            : drop the head entry (ignored when empty)
//   o_head           : current head entry (valid when !o_empty)
//   o_empty, o_count : occupancy
module pf_fifo
  import frame_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  pixel_t                 i_push_data,
  input  logic                   i_pop,
  output pixel_t                 o_head,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  pixel_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = i_push && (count != (AW+1)'(DEPTH));
  assign do_pop  = i_pop && (count != '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem[wr_ptr] <= i_push_data;
  end

  assign o_head  = mem[rd_ptr];
  assign o_empty = (count == '0);
  assign o_count = count;

endmodule

// File: rtl/frame_prefetch.sv
// frame_prefetch: prefetches frame pixels from memory into a show-ahead FIFO
// and pops one pixel each time the display stage moves its pixel address.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_frame_sync     : flush the FIFO and restart fetching at pixel 0
//   i_pixel_addr     : display-stage pixel index (a change pops one entry)
//   o_data           : FIFO head, or last popped pixel while empty
//   o_rd_req/o_rd_addr/i_rd_ack : read request handshake
//   i_rd_valid/i_rd_data        : in-order read returns
//   o_underflow      : sticky, pop attempted on an empty FIFO
//   o_underflow_cnt  : saturating underflow count (FRAME_PREFETCH_STATS_EN only)
module frame_prefetch
  import frame_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH_IMAGE     = 640,
  parameter int unsigned HEIGHT_IMAGE    = 480,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_frame_sync,
  input  logic [18:0] i_pixel_addr,
  output logic [15:0] o_data,
  output logic        o_rd_req,
  output logic [18:0] o_rd_addr,
  input  logic        i_rd_ack,
  input  logic        i_rd_valid,
  input  logic [15:0] i_rd_data,
  output logic        o_underflow
`ifdef FRAME_PREFETCH_STATS_EN
  ,
  output logic [15:0] o_underflow_cnt
`endif
);

  localparam int unsigned TOTAL = WIDTH_IMAGE * HEIGHT_IMAGE;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW    = CW + 1;

  state_t      state_q, state_d;
  logic [OW-1:0] out_q, out_n;
  logic [18:0] addr_q;
  logic [18:0] pix_q;
  pixel_t      last_q;
  logic        uf_q;

  logic [CW-1:0] fifo_count, count_n;
  pixel_t        fifo_head;
  logic          fifo_empty;
  logic [SW-1:0] fill_n;

  logic flush, accept, pop_req, push_do, pop_do, credit_n;

  // A frame sync acts as a flush in its own cycle, so data returned or
  // popped alongside it is dropped just like during FLUSH.
  assign flush   = i_frame_sync || (state_q == ST_FLUSH);
  assign accept  = o_rd_req && i_rd_ack;
  assign pop_req = (i_pixel_addr != pix_q);
  assign push_do = i_rd_valid && !flush;
  assign pop_do  = pop_req && !fifo_empty && !flush;

  pf_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_flush     (flush),
    .i_push      (push_do),
    .i_push_data (i_rd_data),
    .i_pop       (pop_do),
    .o_head      (fifo_head),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  // Credit is judged on next-cycle occupancy so a request is only raised
  // (or kept) when the slot it would consume is really free.
  always_comb begin
    count_n = fifo_count;
    if (push_do && !pop_do)      count_n = fifo_count + CW'(1);
    else if (!push_do && pop_do) count_n = fifo_count - CW'(1);

    out_n = out_q;
    if (accept && !i_rd_valid)      out_n = out_q + OW'(1);
    else if (!accept && i_rd_valid) out_n = out_q - OW'(1);

    fill_n   = SW'(count_n) + SW'(out_n);
    credit_n = (fill_n < SW'(FIFO_DEPTH)) && (out_n < OW'(MAX_OUTSTANDING));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (credit_n) state_d = ST_FETCH;
      ST_FETCH: if (accept && !credit_n) state_d = ST_IDLE;
      ST_FLUSH: if (out_n == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (i_frame_sync) state_d = ST_FLUSH;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
      last_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_n;
      pix_q   <= i_pixel_addr;
      if (flush)       addr_q <= '0;
      else if (accept) addr_q <= addr_wrap_inc(addr_q, TOTAL);
      if (pop_do) last_q <= fifo_head;
      if (pop_req && fifo_empty) uf_q <= 1'b1;
    end
  end

`ifdef FRAME_PREFETCH_STATS_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                   ucnt_q <= '0;
    else if (i_frame_sync)                            ucnt_q <= '0;
    else if (pop_req && fifo_empty && ucnt_q != '1)   ucnt_q <= ucnt_q + 16'd1;
  end

  assign o_underflow_cnt = ucnt_q;
`endif

  assign o_rd_req    = (state_q == ST_FETCH);
  assign o_rd_addr   = addr_q;
  assign o_data      = fifo_empty ? last_q : fifo_head;
  assign o_underflow = uf_q;

endmodule

// File: tb/tb_frame_prefetch.sv
// tb_frame_prefetch: randomized and directed checks of frame_prefetch against
// a queue-based reference model and an in-order memory model.
// Small frame (16x4) so the address wrap is reachable quickly.
module tb_frame_prefetch;
  import frame_prefetch_pkg::*;

  localparam int unsigned W     = 16;
  localparam int unsigned H     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned MAXO  = 4;
  localparam int unsigned TOTAL = W * H;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_frame_sync;
  logic [18:0] i_pixel_addr;
  logic [15:0] o_data;
  logic        o_rd_req;
  logic [18:0] o_rd_addr;
  logic        i_rd_ack;
  logic        i_rd_valid;
  logic [15:0] i_rd_data;
  logic        o_underflow;
`ifdef FRAME_PREFETCH_STATS_EN
  logic [15:0] o_underflow_cnt;
`endif

  always #5 clk = ~clk;

  frame_prefetch #(
    .WIDTH_IMAGE     (W),
    .HEIGHT_IMAGE    (H),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_frame_sync (i_frame_sync),
    .i_pixel_addr (i_pixel_addr),
    .o_data       (o_data),
    .o_rd_req     (o_rd_req),
    .o_rd_addr    (o_rd_addr),
    .i_rd_ack     (i_rd_ack),
    .i_rd_valid   (i_rd_valid),
    .i_rd_data    (i_rd_data),
    .o_underflow  (o_underflow)
`ifdef FRAME_PREFETCH_STATS_EN
    ,
    .o_underflow_cnt (o_underflow_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model state
  pixel_t      mq[$];
  int unsigned m_out;
  bit          m_flushing;
  logic [18:0] m_addr;
  pixel_t      m_last;
  bit          m_uf;
  int unsigned m_ucnt;
  logic [18:0] m_prev_pix;

  // memory model
  logic [18:0] pend_addr[$];
  int unsigned pend_due[$];
  int unsigned cyc = 0;
  pixel_t      mem_xor = '0;
  int unsigned lat_min = 2, lat_max = 2;
  int          ack_mode = 0;   // 0 always, 1 never, 2 random
  bit          mem_stall = 0;

  // bookkeeping
  bit          prev_wait;
  logic [18:0] prev_req_addr;
  int unsigned n_accepts;
  logic [18:0] last_acc_addr;
  bit          saw_wrap = 0;
  bit          want_first;
  bit          got_first;
  logic [18:0] first_post_addr;
  logic [18:0] pix;

  function automatic pixel_t mem_word(input logic [18:0] a);
    return a[15:0] ^ mem_xor;
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input logic [18:0] p, input bit sync);
    bit     ack, acc, ret, pop_req, uf_pop;
    pixel_t rdat;
    @(negedge clk);
    check("o_data", o_data, (mq.size() != 0) ? mq[0] : m_last);
    check("o_underflow", o_underflow, m_uf);
`ifdef FRAME_PREFETCH_STATS_EN
    check("o_underflow_cnt", o_underflow_cnt, m_ucnt);
`endif
    if (m_flushing) check("req_in_flush", o_rd_req, 0);
    if (o_rd_req) begin
      check("credit", ((mq.size() + m_out) < DEPTH) && (m_out < MAXO), 1);
      check("rd_addr", o_rd_addr, m_addr);
    end
    if (prev_wait) begin
      check("req_hold", o_rd_req, 1);
      check("addr_hold", o_rd_addr, prev_req_addr);
    end

    case (ack_mode)
      0:       ack = 1'b1;
      1:       ack = 1'b0;
      default: ack = ($urandom_range(3) != 0);
    endcase
    ret  = 1'b0;
    rdat = pixel_t'($urandom);
    if (!mem_stall && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      ret  = 1'b1;
      rdat = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    i_pixel_addr = p;
    i_frame_sync = sync;
    i_rd_ack     = ack;
    i_rd_valid   = ret;
    i_rd_data    = rdat;
    acc = o_rd_req && ack;

    pop_req = (p != m_prev_pix);
    uf_pop  = pop_req && (mq.size() == 0);
    if (uf_pop) m_uf = 1'b1;
    if (sync) m_ucnt = 0;
    else if (uf_pop && m_ucnt < 65535) m_ucnt++;
    if (sync || m_flushing) mq.delete();
    else begin
      if (pop_req && mq.size() != 0) m_last = mq.pop_front();
      if (ret) mq.push_back(rdat);
    end
    if (acc) begin
      pend_addr.push_back(o_rd_addr);
      pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
      n_accepts++;
      if (o_rd_addr == 0 && last_acc_addr == 19'(TOTAL - 1)) saw_wrap = 1'b1;
      last_acc_addr = o_rd_addr;
      if (want_first && !sync) begin
        first_post_addr = o_rd_addr;
        got_first  = 1'b1;
        want_first = 1'b0;
      end
    end
    m_out = m_out + acc - ret;
    if (sync || m_flushing) m_addr = '0;
    else if (acc) m_addr = (m_addr == 19'(TOTAL - 1)) ? '0 : m_addr + 19'd1;
    if (sync) begin
      m_flushing = 1'b1;
      want_first = 1'b1;
      got_first  = 1'b0;
    end else if (m_flushing && m_out == 0) m_flushing = 1'b0;
    m_prev_pix    = p;
    prev_wait     = o_rd_req && !ack && !sync;
    prev_req_addr = o_rd_addr;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset_n = 1'b0; i_frame_sync = 1'b0; i_pixel_addr = '0;
    i_rd_ack = 1'b0; i_rd_valid = 1'b0; i_rd_data = '0;
    mq.delete(); pend_addr.delete(); pend_due.delete();
    m_out = 0; m_flushing = 0; m_addr = '0; m_last = '0; m_uf = 0; m_ucnt = 0;
    m_prev_pix = '0; prev_wait = 0; n_accepts = 0; last_acc_addr = '0;
    want_first = 0; got_first = 0; pix = '0;
    repeat (2) @(negedge clk);
    check("rst_rd_req", o_rd_req, 0);
    check("rst_rd_addr", o_rd_addr, 0);
    check("rst_data", o_data, 0);
    check("rst_underflow", o_underflow, 0);
`ifdef FRAME_PREFETCH_STATS_EN
    check("rst_underflow_cnt", o_underflow_cnt, 0);
`endif
    i_reset_n = 1'b1;
  endtask

  initial begin
    // fill after reset: 0-latency ack, returns 2 cycles later
    do_reset();
    ack_mode = 0; lat_min = 2; lat_max = 2; mem_xor = '0;
    repeat (40) step(0, 0);
    check("fill_accepts", n_accepts, 16);
    check("fill_last_addr", last_acc_addr, 15);
    check("fill_req_drop", o_rd_req, 0);

    // display steps 0,1,2 with data == address; ack withheld from here
    ack_mode = 1;
    check("step0_data", o_data, 16'h0000);
    step(1, 0);
    @(posedge clk); #1;
    check("step1_data", o_data, 16'h0001);
    step(2, 0);
    @(posedge clk); #1;
    check("step2_data", o_data, 16'h0002);

    // ack held low 10 cycles: request and address hold, FIFO unchanged
    repeat (10) step(2, 0);
    @(posedge clk); #1;
    check("stall_req", o_rd_req, 1);
    check("stall_addr", o_rd_addr, 16);
    check("stall_data", o_data, 16'h0002);
    ack_mode = 0;
    repeat (10) step(2, 0);

    // frame sync with 3 reads outstanding (addresses 5..7)
    do_reset();
    mem_xor = 16'h5A5A; ack_mode = 0; lat_min = 2; lat_max = 2;
    for (int unsigned i = 0; i < 100 && n_accepts < 5; i++) step(0, 0);
    ack_mode = 1;
    for (int unsigned i = 0; i < 100 && m_out != 0; i++) step(0, 0);
    lat_min = 10; lat_max = 10; ack_mode = 0;
    for (int unsigned i = 0; i < 100 && m_out != 3; i++) step(0, 0);
    check("sync_outstanding", m_out, 3);
    ack_mode = 1;
    step(0, 1);
    ack_mode = 0; lat_min = 2; lat_max = 2;
    repeat (50) step(0, 0);
    check("post_sync_seen", got_first, 1);
    check("post_sync_addr", first_post_addr, 0);
    @(posedge clk); #1;
    check("post_sync_data", o_data, 16'h5A5A);

    // memory stalled while the display drains the FIFO and keeps going
    ack_mode = 1; mem_stall = 1;
    for (int unsigned k = 1; k <= 24; k++) step(19'(k), 0);
    @(posedge clk); #1;
    check("uf_flag", o_underflow, 1);
    check("uf_hold_data", o_data, 16'h5A55);
`ifdef FRAME_PREFETCH_STATS_EN
    check("uf_count", o_underflow_cnt, 8);
`endif
    repeat (3) step(24, 0);
    mem_stall = 0;

    // address wrap at the last pixel of the frame
    do_reset();
    ack_mode = 0; lat_min = 1; lat_max = 1; mem_xor = 16'h1234;
    for (int unsigned i = 0; i < 200; i++) begin
      if (i[0]) pix = pix + 19'd1;
      step(pix, 0);
    end
    check("wrap_seen", saw_wrap, 1);

    // randomized traffic, including syncs that overlap accepts
    do_reset();
    ack_mode = 2; lat_min = 1; lat_max = 4; mem_xor = pixel_t'($urandom);
    for (int unsigned i = 0; i < 3000; i++) begin
      bit s;
      s = ($urandom_range(299) == 0);
      if (!s && $urandom_range(2) == 0) pix = pix + 19'd1;
      step(pix, s);
    end

    // reset during in-flight reads
    do_reset();
    repeat (20) step(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
